clk_div_ctrl: RTL and testbench

Run/stop sequencer and ratio configurator for the design's 50 % duty clock divider. It generates the divided clock O_CLK from I_CLK and accepts new divide ratios over a valid/ready port. Ratio changes and stops take effect only at a period boundary, so O_CLK never has a runt pulse. It drives the divided-clock domain and exposes a per-period tick for downstream logic.

---
 rtl/clk_div_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop sequencer and ratio configurator for a 50 % duty
// clock divider. O_CLK has a period of 2*cur_div I_CLK cycles; new ratios
// and stops only take effect at a period boundary (end of the low half),
// so O_CLK never produces a runt pulse.
// Optional feature macro: DIVCTRL_CLAMP_EN (nonzero ratios below 2 become 2).
module clk_div_ctrl #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 50
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             O_CLK,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend;
  logic             r_oclk;
  logic             r_tick;
  logic             r_busy;

  logic [DIV_W-1:0] w_cfg_val;
  logic [DIV_W-1:0] w_next_div;
  logic [DIV_W-1:0] w_idle_div;
  logic             w_accept;
  logic             w_last;
  logic             w_boundary;

  // Ratio as it will be stored; the clamp keeps the period at 4 cycles or more.
`ifdef DIVCTRL_CLAMP_EN
  assign w_cfg_val = (cfg_div == DIV_W'(1)) ? DIV_W'(2) : cfg_div;
`else
  assign w_cfg_val = cfg_div;
`endif

  // The single shadow slot is free whenever nothing is pending.
  assign w_accept   = cfg_valid && !r_pend;
  assign w_last     = (r_cnt == r_cur_div - DIV_W'(1));
  // End of the low half is the only place ratio changes and stops happen.
  assign w_boundary = w_last && !r_oclk;
  assign w_next_div = r_pend ? r_pend_div : r_cur_div;
  // Starting from IDLE uses the ratio that will be in effect after this
  // edge, so a simultaneous write of 0 can never launch a zero-length run.
  assign w_idle_div = w_accept ? w_cfg_val : r_cur_div;

  // Sequencer: IDLE/RUN/DRAIN state, half-period counter, ratio registers
  // and all registered outputs.
  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_div  <= DIV_W'(DEF_DIV);
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_oclk     <= 1'b0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_oclk <= 1'b0;
          if (w_accept) begin
            r_cur_div <= w_cfg_val;
          end
          if (en && (w_idle_div != '0)) begin
            r_state <= S_RUN;
            r_oclk  <= 1'b1;
            r_tick  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            r_pend_div <= w_cfg_val;
            r_pend     <= 1'b1;
          end
          if (w_boundary) begin
            r_cnt <= '0;
            if (r_pend) begin
              r_cur_div <= r_pend_div;
              r_pend    <= 1'b0;
            end
            if ((w_next_div == '0) || !en) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_oclk  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_oclk  <= 1'b1;
              r_tick  <= 1'b1;
            end
          end else begin
            r_state <= en ? S_RUN : S_DRAIN;
            if (w_last) begin
              r_cnt  <= '0;
              r_oclk <= ~r_oclk;
            end else begin
              r_cnt <= r_cnt + DIV_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign cfg_ready = !r_pend;
  assign O_CLK     = r_oclk;
  assign tick      = r_tick;
  assign cur_div   = r_cur_div;
  assign busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: vector table, directed corner sequences and randomized
// traffic for clk_div_ctrl, checked against a period-position reference model.
module tb_clk_div_ctrl;

  localparam int W = 16;

  logic         I_CLK;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         O_CLK;
  logic         tick;
  logic [W-1:0] cur_div;
  logic         busy;

  int total;
  int bad;
  int stepNo;
  int tickQ[$];

  // Reference model: position inside the current period plus ratio state.
  bit mRun;
  bit mPend;
  bit mOclk;
  bit mTick;
  int mPos;
  int mCur;
  int mPendVal;

  typedef struct {
    bit r;
    bit e;
    bit v;
    int d;
    bit oclk;
    bit tk;
    bit bsy;
    bit rdy;
    int cur;
  } vec_t;

  vec_t tbl[20];

  clk_div_ctrl #(.DIV_W(W), .DEF_DIV(50)) dut (
    .I_CLK    (I_CLK),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .O_CLK    (O_CLK),
    .tick     (tick),
    .cur_div  (cur_div),
    .busy     (busy)
  );

  // 10-unit system clock
  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelStep(input bit r, input bit e, input bit v, input int d);
    int  val;
    int  eff;
    bit  acc;
    val = d;
`ifdef DIVCTRL_CLAMP_EN
    if (val == 1) val = 2;
`endif
    if (!r) begin
      mRun = 0; mPend = 0; mOclk = 0; mTick = 0; mPos = 0; mCur = 50; mPendVal = 0;
      return;
    end
    acc = v && !mPend;
    mTick = 0;
    if (!mRun) begin
      eff = acc ? val : mCur;
      if (acc) mCur = val;
      mOclk = 0;
      if (e && eff != 0) begin
        mRun = 1; mPos = 0; mOclk = 1; mTick = 1;
      end
    end else begin
      if (mPos + 1 == 2 * mCur) begin
        if (mPend) begin
          mCur = mPendVal; mPend = 0;
        end
        if (!e || mCur == 0) begin
          mRun = 0; mOclk = 0; mPos = 0;
        end else begin
          mPos = 0; mOclk = 1; mTick = 1;
        end
      end else begin
        mPos = mPos + 1;
        mOclk = (mPos < mCur);
      end
      if (acc) begin
        mPend = 1; mPendVal = val;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input int d);
    rst       = r;
    en        = e;
    cfg_valid = v;
    cfg_div   = W'(d);
    modelStep(r, e, v, d);
    @(posedge I_CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W+3:0] exp);
    logic [W+3:0] act;
    act = {O_CLK, tick, busy, cfg_ready, cur_div};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step=%0d: got {oclk,tick,busy,ready,cur}=%b,%b,%b,%b,%0d expected %b,%b,%b,%b,%0d",
               name, stepNo, act[W+3], act[W+2], act[W+1], act[W], act[W-1:0],
               exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelCheck(input string name);
    checkOutput(name, {mOclk, mTick, mRun, ~mPend, W'(mCur)});
  endtask

  task automatic stepCheck(input string name, input bit r, input bit e, input bit v, input int d);
    applyStimulus(r, e, v, d);
    modelCheck(name);
    if (tick) tickQ.push_back(stepNo);
    stepNo++;
  endtask

  task automatic runSteps(input int n, input bit e);
    for (int i = 0; i < n; i++) stepCheck("run", 1'b1, e, 1'b0, 0);
  endtask

  task automatic waitTick(input int maxSteps, input bit e);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxSteps && !seen; i++) begin
      stepCheck("wait", 1'b1, e, 1'b0, 0);
      if (tick) seen = 1;
    end
    if (!seen) checkVal("wait_tick_timeout", 0, 1);
  endtask

  initial begin
    int highs;
    int rises;
    bit prev;
    bit rr;
    bit re;
    bit rv;
    int rd;
    total = 0; bad = 0; stepNo = 0;
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    modelStep(0, 0, 0, 0);

    // r e v d | oclk tick busy ready cur
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 1, 50};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 50};
    tbl[2]  = '{1, 0, 1, 2, 0, 0, 0, 1, 2};
    tbl[3]  = '{1, 1, 0, 0, 1, 1, 1, 1, 2};
    tbl[4]  = '{1, 1, 0, 0, 1, 0, 1, 1, 2};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 1, 1, 2};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 1, 1, 2};
    tbl[7]  = '{1, 1, 0, 0, 1, 1, 1, 1, 2};
    tbl[8]  = '{1, 1, 1, 3, 1, 0, 1, 0, 2};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 1, 0, 2};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 1, 0, 2};
    tbl[11] = '{1, 1, 0, 0, 1, 1, 1, 1, 3};
    tbl[12] = '{1, 1, 0, 0, 1, 0, 1, 1, 3};
    tbl[13] = '{1, 1, 0, 0, 1, 0, 1, 1, 3};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 1, 3};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 1, 3};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 1, 1, 3};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 0, 1, 3};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 0, 1, 3};
    tbl[19] = '{1, 1, 0, 0, 1, 1, 1, 1, 3};

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
      checkOutput($sformatf("table[%0d]", i),
                  {tbl[i].oclk, tbl[i].tk, tbl[i].bsy, tbl[i].rdy, W'(tbl[i].cur)});
      stepNo++;
    end

    // Default ratio: first rise one cycle after en, 50 high / 50 low, tick every 100
    stepCheck("reset0", 1'b0, 1'b0, 1'b0, 0);
    stepCheck("reset1", 1'b0, 1'b0, 1'b0, 0);
    tickQ.delete();
    highs = 0;
    for (int k = 0; k < 225; k++) begin
      stepCheck("default", 1'b1, 1'b1, 1'b0, 0);
      if (k < 100 && O_CLK) highs++;
    end
    checkVal("default_highs", highs, 50);
    checkVal("default_ticks", tickQ.size(), 3);
    if (tickQ.size() >= 3) begin
      checkVal("default_period_a", tickQ[1] - tickQ[0], 100);
      checkVal("default_period_b", tickQ[2] - tickQ[1], 100);
    end
    checkVal("default_cur", int'(cur_div), 50);

    // Ratio change mid-high-phase: held pending until the boundary
    stepCheck("cfg3_send", 1'b1, 1'b1, 1'b1, 3);
    checkVal("cfg3_ready_low", int'(cfg_ready), 0);
    tickQ.delete();
    runSteps(120, 1'b1);
    checkVal("cfg3_cur", int'(cur_div), 3);
    if (tickQ.size() >= 2)
      checkVal("cfg3_period", tickQ[tickQ.size()-1] - tickQ[tickQ.size()-2], 6);
    else
      checkVal("cfg3_ticks", tickQ.size(), 2);

    // Stop in the middle of a high phase: period completes, ends low and idle
    waitTick(20, 1'b1);
    stepCheck("stop_pos1", 1'b1, 1'b1, 1'b0, 0);
    runSteps(6, 1'b0);
    checkVal("stop_oclk", int'(O_CLK), 0);
    checkVal("stop_busy", int'(busy), 0);

    // Re-raising en before the boundary keeps the period intact
    tickQ.delete();
    runSteps(3, 1'b1);
    runSteps(2, 1'b0);
    runSteps(9, 1'b1);
    checkVal("regap_ticks", tickQ.size(), 3);
    if (tickQ.size() >= 3) begin
      checkVal("regap_period_a", tickQ[1] - tickQ[0], 6);
      checkVal("regap_period_b", tickQ[2] - tickQ[1], 6);
    end

    // Ratio 0 while running at N=4 stops at the boundary and holds IDLE
    stepCheck("cfg4_send", 1'b1, 1'b1, 1'b1, 4);
    runSteps(12, 1'b1);
    checkVal("cfg4_cur", int'(cur_div), 4);
    stepCheck("cfg0_send", 1'b1, 1'b1, 1'b1, 0);
    runSteps(12, 1'b1);
    checkVal("zero_stop_busy", int'(busy), 0);
    checkVal("zero_stop_oclk", int'(O_CLK), 0);
    runSteps(5, 1'b1);
    checkVal("zero_hold_busy", int'(busy), 0);
    stepCheck("cfg5_start", 1'b1, 1'b1, 1'b1, 5);
    checkVal("cfg5_busy", int'(busy), 1);

    // Reset mid-period with a pending ratio discards it
    runSteps(3, 1'b1);
    stepCheck("pend_send", 1'b1, 1'b1, 1'b1, 2);
    checkVal("pend_ready_low", int'(cfg_ready), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("midreset", {1'b0, 1'b0, 1'b0, 1'b1, W'(50)});
    stepNo++;
    stepCheck("after_reset", 1'b1, 1'b0, 1'b0, 0);

    // Ratio 1: I_CLK/2 normally, period 4 when clamped
    stepCheck("cfg1_send", 1'b1, 1'b0, 1'b1, 1);
    rises = 0;
    prev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      stepCheck("cfg1_run", 1'b1, 1'b1, 1'b0, 0);
      if (O_CLK && !prev) rises++;
      prev = O_CLK;
    end
`ifdef DIVCTRL_CLAMP_EN
    checkVal("cfg1_rises", rises, 5);
`else
    checkVal("cfg1_rises", rises, 10);
`endif

    // Randomized traffic against the model
    re = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rr = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) re = ~re;
      rv = ($urandom_range(0, 3) == 0);
      rd = int'($urandom_range(0, 5));
      stepCheck("random", rr, re, rv, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
